// File: rtl/clock_enable_gen.sv
// clock_enable_gen: per-channel programmable clock-enable ticks and square waves in the boardCLK domain.
// Divisor writes land in a shadow and take effect only at a wrap, sync, stall or while disabled.
module clock_enable_gen #(
   parameter int NUM_CH = 2,
   parameter int CH_W = 1,
   parameter int CNT_W = 16,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd4096, 16'd4}
) (
   input  logic              boardCLK,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq,
   output logic [NUM_CH-1:0] pending
);
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [CNT_W-1:0] INIT = DIV_INIT[c*CNT_W +: CNT_W];
      logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
      logic tick_q, tick_d, sq_q, sq_d, pend_q, pend_d, wr, apply;
      always_comb begin
         cnt_d = cnt_q;
         tick_d = 1'b0;
         sq_d = sq_q;
         apply = pend_q;
         if (sync) begin
            cnt_d = '0;
            sq_d = 1'b0;
         end else if (ch_en[c]) begin
            if (act_q == '0) cnt_d = '0;
            else if (cnt_q >= act_q - CNT_W'(1)) begin
               cnt_d = '0;
               tick_d = 1'b1;
               sq_d = ~sq_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               apply = 1'b0;
            end
         end
         // a write in the same cycle only reaches the shadow, never the active divisor
         wr = cfg_we && cfg_ch == CH_W'(c);
         act_d = apply ? shd_q : act_q;
         shd_d = wr ? cfg_div : shd_q;
         pend_d = wr | (pend_q & ~apply);
      end
      always_ff @(posedge boardCLK) begin
         if (reset) begin
            cnt_q <= '0;
            tick_q <= 1'b0;
            sq_q <= 1'b0;
            pend_q <= 1'b0;
            act_q <= INIT;
            shd_q <= INIT;
         end else begin
            cnt_q <= cnt_d;
            tick_q <= tick_d;
            sq_q <= sq_d;
            pend_q <= pend_d;
            act_q <= act_d;
            shd_q <= shd_d;
         end
      end
      assign tick[c] = tick_q;
      assign sq[c] = sq_q;
      assign pending[c] = pend_q;
   end
endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen: directed and random stimulus checked every cycle against a behavioural model.
module tb_clock_enable_gen;
   logic clk = 1'b0;
   logic reset, sync, cfg_we;
   logic [1:0] ch_en, cfg_ch, tick, sq, pending;
   logic [15:0] cfg_div;
   int tests = 0, fails = 0;
   int m_cnt[2], m_div[2], m_shd[2];
   bit m_tick[2], m_sq[2], m_pend[2];
   bit started = 0;

   always #5 clk = ~clk;

   clock_enable_gen #(.NUM_CH(2), .CH_W(2), .CNT_W(16), .DIV_INIT({16'd4096, 16'd4})) dut (
      .boardCLK(clk), .reset(reset), .ch_en(ch_en), .sync(sync), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick), .sq(sq), .pending(pending)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Reference: apply the first matching rule per channel, then the pending/shadow bookkeeping.
   always @(posedge clk) begin
      started = 1;
      for (int c = 0; c < 2; c++) begin
         bit ap, wr;
         wr = cfg_we && cfg_ch == c;
         if (reset) begin
            m_cnt[c] = 0; m_tick[c] = 0; m_sq[c] = 0; m_pend[c] = 0;
            m_div[c] = c ? 4096 : 4; m_shd[c] = m_div[c];
         end else begin
            ap = m_pend[c];
            m_tick[c] = 0;
            if (sync) begin m_cnt[c] = 0; m_sq[c] = 0; end
            else if (!ch_en[c]) ;
            else if (m_div[c] == 0) m_cnt[c] = 0;
            else if (m_cnt[c] + 1 >= m_div[c]) begin m_cnt[c] = 0; m_tick[c] = 1; m_sq[c] = !m_sq[c]; end
            else begin m_cnt[c]++; ap = 0; end
            if (ap) begin m_div[c] = m_shd[c]; m_pend[c] = 0; end
            if (wr) begin m_shd[c] = cfg_div; m_pend[c] = 1; end
         end
      end
   end

   always @(negedge clk) if (started) begin
      chk("tick", tick, {m_tick[1], m_tick[0]});
      chk("sq", sq, {m_sq[1], m_sq[0]});
      chk("pending", pending, {m_pend[1], m_pend[0]});
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1; sync = 0; cfg_we = 0; ch_en = 2'b11; cfg_ch = 0; cfg_div = 0;
      step(2);
      chk("reset_out", {tick, sq, pending}, 0);
      reset = 0;
      step(3); chk("t0_c3", tick[0], 0);
      step(1); chk("t0_c4", tick[0], 1); chk("sq0_c4", sq[0], 1);
      step(1); cfg_we = 1; cfg_ch = 0; cfg_div = 3;
      step(1); cfg_we = 0; chk("pend0_set", pending[0], 1);
      step(2); chk("t0_c8", tick[0], 1); chk("pend0_clr", pending[0], 0);
      step(2); chk("t0_c10", tick[0], 0);
      step(1); chk("t0_c11", tick[0], 1); chk("sq0_c11", sq[0], 1);
      step(4084); chk("t1_c4095", tick[1], 0);
      step(1); chk("t1_c4096", tick[1], 1);
      step(2000); sync = 1;
      step(1); sync = 0; chk("sync_tick", tick, 0); chk("sync_sq", sq, 0);
      step(3); chk("t0_after_sync", tick[0], 1);
      step(4093); chk("t1_after_sync", tick[1], 1);
      cfg_we = 1; cfg_ch = 3; cfg_div = 7;
      step(1); cfg_we = 0; chk("ch3_ignored", pending, 0);
      cfg_we = 1; cfg_ch = 0; cfg_div = 1;
      step(1); cfg_div = 0;
      step(1); cfg_we = 0;
      step(10);
      chk("div0_stall", tick[0], 0);
      ch_en = 2'b10; step(10); ch_en = 2'b11; step(5);
      cfg_we = 1; cfg_ch = 1; cfg_div = 5;
      step(1); cfg_we = 0; reset = 1;
      step(1); reset = 0; chk("mid_reset", {tick, sq, pending}, 0);
      step(4); chk("t0_after_reset", tick[0], 1);
      for (int i = 0; i < 30000; i++) begin
         step(1);
         reset = ($urandom % 500) == 0;
         sync = ($urandom % 200) == 0;
         ch_en = {($urandom % 16) != 0, ($urandom % 16) != 0};
         cfg_we = ($urandom % 20) == 0;
         cfg_ch = 2'($urandom % 4);
         cfg_div = ($urandom % 8 == 0) ? 16'($urandom_range(0, 63)) : 16'($urandom_range(0, 9));
      end
      reset = 0; sync = 0; cfg_we = 0;
      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
